// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline hazard controller and the datapath.
// The controller drives the slave modport. The datapath, or a testbench, uses master.
interface pipe_ctrl_if #(
    parameter int unsigned NSTAGE = 5,
    parameter int unsigned CNT_W  = 64
);
    // Hazard and status inputs to the controller
    logic              iresp_ok;
    logic              dmem_busy;
    logic              redirect_valid;
    logic [4:0]        dec_rs1;
    logic [4:0]        dec_rs2;
    logic              dec_rs1_used;
    logic              dec_rs2_used;
    logic [4:0]        dec_rd;
    logic              dec_regwrite;
    logic              dec_memread;

    // Pipeline steering and status outputs
    logic [NSTAGE-1:0] stage_en;
    logic [NSTAGE-1:0] stage_bubble;
    logic [NSTAGE-1:0] stage_valid;
    logic              pc_en;
    logic              pc_redirect;
    logic              commit_valid;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output iresp_ok, dmem_busy, redirect_valid,
        output dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
        output dec_rd, dec_regwrite, dec_memread,
        input  stage_en, stage_bubble, stage_valid,
        input  pc_en, pc_redirect, commit_valid,
        input  cycle_cnt, instr_cnt, stall_cnt
    );

    modport slave (
        input  iresp_ok, dmem_busy, redirect_valid,
        input  dec_rs1, dec_rs2, dec_rs1_used, dec_rs2_used,
        input  dec_rd, dec_regwrite, dec_memread,
        output stage_en, stage_bubble, stage_valid,
        output pc_en, pc_redirect, commit_valid,
        output cycle_cnt, instr_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// In-order pipeline hazard controller.
// It handles stall and freeze propagation, bubble insertion, load-use detection,
// redirect flush, the slot valid bits and the performance counters.
module pipe_ctrl #(
    parameter int unsigned NSTAGE    = 5,
    parameter int unsigned BR_STAGE  = 2,
    parameter int unsigned MEM_STAGE = 3,
    parameter int unsigned CNT_W     = 64
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [NSTAGE-1:0]      valid_q, valid_d;
    logic [NSTAGE-1:0]      hold;
    logic [NSTAGE-1:0]      freeze;
    logic [NSTAGE-1:0]      stage_en;
    logic [NSTAGE-1:0]      stage_bubble;
    logic                   load_use;
    logic                   rs1_hit;
    logic                   rs2_hit;
    logic                   redirect_take;

    // Scoreboard covers slots 2..NSTAGE-1 only
    logic [NSTAGE-1:2][4:0] sb_rd_q, sb_rd_d;
    logic [NSTAGE-1:2]      sb_rw_q, sb_rw_d;
    logic [NSTAGE-1:2]      sb_mr_q, sb_mr_d;

    logic [CNT_W-1:0]       cycle_q, instr_q, stall_q;

    // The retiring slot's scoreboard entry only feeds the shift chain
    logic unused_sb_tail;
    assign unused_sb_tail = ^{sb_rd_q[NSTAGE-1], sb_rw_q[NSTAGE-1], sb_mr_q[NSTAGE-1]};

    // Load-use: slot 1 reads a register that the load in slot 2 has not produced yet
    always_comb begin
        rs1_hit  = bus.dec_rs1_used && (bus.dec_rs1 == sb_rd_q[2]);
        rs2_hit  = bus.dec_rs2_used && (bus.dec_rs2 == sb_rd_q[2]);
        load_use = valid_q[1] && valid_q[2] && sb_mr_q[2] && sb_rw_q[2] &&
                   (sb_rd_q[2] != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Hold requests, backward freeze propagation, redirect arbitration and bubbles
    always_comb begin
        logic acc;
        acc            = 1'b0;
        hold           = '0;
        freeze         = '0;
        stage_bubble   = '0;

        hold[0]         = !bus.iresp_ok;
        hold[1]         = load_use;
        hold[MEM_STAGE] = bus.dmem_busy && valid_q[MEM_STAGE];

        // A hold in slot j freezes every older-in-pipe slot k <= j
        for (int k = int'(NSTAGE) - 1; k >= 0; k--) begin
            acc       = acc | hold[k];
            freeze[k] = acc;
        end

        // A redirect is only taken when its own slot is free to advance
        redirect_take = !reset && bus.redirect_valid && valid_q[BR_STAGE] &&
                        !freeze[BR_STAGE];

        // A taken redirect overrides fetch and load-use holds
        if (redirect_take) begin
            for (int k = 0; k <= int'(BR_STAGE); k++) begin
                freeze[k] = 1'b0;
            end
        end

        if (reset) begin
            freeze = '0;
        end

        for (int k = 1; k < int'(NSTAGE); k++) begin
            stage_bubble[k] = freeze[k-1] & ~freeze[k];
        end

        // Wrong-path slots behind the redirect load bubbles
        if (redirect_take) begin
            for (int k = 1; k <= int'(BR_STAGE); k++) begin
                stage_bubble[k] = 1'b1;
            end
        end

        stage_en = ~freeze;
    end

    // Next-state for the slot valid bits
    always_comb begin
        valid_d    = valid_q;
        valid_d[0] = 1'b1;
        // Slot 1 that loads without a bubble always receives a completed fetch
        if (stage_en[1]) begin
            valid_d[1] = !stage_bubble[1];
        end
        for (int k = 2; k < int'(NSTAGE); k++) begin
            if (stage_en[k]) begin
                valid_d[k] = stage_bubble[k] ? 1'b0 : valid_q[k-1];
            end
        end
    end

    // Next-state for the scoreboard, which shifts in lockstep with the slots
    always_comb begin
        sb_rd_d = sb_rd_q;
        sb_rw_d = sb_rw_q;
        sb_mr_d = sb_mr_q;
        if (stage_en[2]) begin
            if (stage_bubble[2]) begin
                sb_rd_d[2] = 5'd0;
                sb_rw_d[2] = 1'b0;
                sb_mr_d[2] = 1'b0;
            end else begin
                sb_rd_d[2] = valid_q[1] ? bus.dec_rd : 5'd0;
                sb_rw_d[2] = valid_q[1] && bus.dec_regwrite;
                sb_mr_d[2] = valid_q[1] && bus.dec_memread;
            end
        end
        for (int k = 3; k < int'(NSTAGE); k++) begin
            if (stage_en[k]) begin
                if (stage_bubble[k]) begin
                    sb_rd_d[k] = 5'd0;
                    sb_rw_d[k] = 1'b0;
                    sb_mr_d[k] = 1'b0;
                end else begin
                    sb_rd_d[k] = sb_rd_q[k-1];
                    sb_rw_d[k] = sb_rw_q[k-1];
                    sb_mr_d[k] = sb_mr_q[k-1];
                end
            end
        end
    end

    // Slot valid and scoreboard state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            sb_rd_q <= '0;
            sb_rw_q <= '0;
            sb_mr_q <= '0;
        end else begin
            valid_q <= valid_d;
            sb_rd_q <= sb_rd_d;
            sb_rw_q <= sb_rw_d;
            sb_mr_q <= sb_mr_d;
        end
    end

    // Free-running performance counters that wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            cycle_q <= cycle_q + CntOne;
            if (valid_q[NSTAGE-1]) begin
                instr_q <= instr_q + CntOne;
            end
            if (freeze[1]) begin
                stall_q <= stall_q + CntOne;
            end
        end
    end

    assign bus.stage_en     = stage_en;
    assign bus.stage_bubble = stage_bubble;
    assign bus.stage_valid  = valid_q;
    assign bus.pc_en        = !freeze[0];
    assign bus.pc_redirect  = redirect_take;
    assign bus.commit_valid = valid_q[NSTAGE-1] && !reset;
    assign bus.cycle_cnt    = cycle_q;
    assign bus.instr_cnt    = instr_q;
    assign bus.stall_cnt    = stall_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with NSTAGE=5, BR_STAGE=2, MEM_STAGE=3 and 8-bit counters.
module tb_pipe_ctrl;

    localparam int unsigned NSTAGE = 5;
    localparam int unsigned CNT_W  = 8;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_cycle;
    logic [7:0] exp_instr;
    logic [7:0] exp_stall;

    always #5 clk = ~clk;

    pipe_ctrl_if #(.NSTAGE(NSTAGE), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .NSTAGE   (NSTAGE),
        .BR_STAGE (2),
        .MEM_STAGE(3),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Count one comparison and report it on mismatch
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                           input logic u2, input logic [4:0] rd, input logic rw,
                           input logic mr);
        bus.dec_rs1      = rs1;
        bus.dec_rs1_used = u1;
        bus.dec_rs2      = rs2;
        bus.dec_rs2_used = u2;
        bus.dec_rd       = rd;
        bus.dec_regwrite = rw;
        bus.dec_memread  = mr;
    endtask

    // Run one non-reset cycle. This checks commit and slot-1 freeze, then updates the model counters.
    task automatic tick(input logic exp_commit, input logic exp_frz1);
        #1;
        check("commit_valid", 32'(bus.commit_valid), 32'(exp_commit));
        check("stage_en1", 32'(bus.stage_en[1]), 32'(!exp_frz1));
        @(posedge clk);
        #1;
        exp_cycle = exp_cycle + 8'd1;
        if (exp_commit) exp_instr = exp_instr + 8'd1;
        if (exp_frz1) exp_stall = exp_stall + 8'd1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cycle"}, 32'(bus.cycle_cnt), 32'(exp_cycle));
        check({tag, "_instr"}, 32'(bus.instr_cnt), 32'(exp_instr));
        check({tag, "_stall"}, 32'(bus.stall_cnt), 32'(exp_stall));
    endtask

    initial begin
        int guard;
        reset              = 1'b1;
        bus.iresp_ok       = 1'b1;
        bus.dmem_busy      = 1'b0;
        bus.redirect_valid = 1'b0;
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        exp_cycle = 8'd0;
        exp_instr = 8'd0;
        exp_stall = 8'd0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stage_en", 32'(bus.stage_en), 32'(5'b11111));
        check("rst_pc_redirect", 32'(bus.pc_redirect), 32'(1'b0));
        check("rst_commit", 32'(bus.commit_valid), 32'(1'b0));
        check("rst_valid", 32'(bus.stage_valid), 32'(5'b00000));
        check_counters("rst");

        // Pipeline fill with no hazards
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(i >= 5, 1'b0);
            check("fill_valid", 32'(bus.stage_valid),
                  (i >= 4) ? 32'h1f : ((32'd1 << (i + 1)) - 32'd1));
        end
        check("fill_cycle8", 32'(bus.cycle_cnt), 32'd8);
        check("fill_instr_n4", 32'(bus.instr_cnt), 32'd4);
        check_counters("fill");

        // Load to x5, then an add that reads x5 through rs1
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        tick(1'b1, 1'b0);
        set_dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        #1;
        check("lu_stage_en", 32'(bus.stage_en), 32'(5'b11100));
        check("lu_bubble", 32'(bus.stage_bubble), 32'(5'b00100));
        check("lu_pc_en", 32'(bus.pc_en), 32'(1'b0));
        tick(1'b1, 1'b1);
        check("lu_valid0", 32'(bus.stage_valid), 32'(5'b11011));
        check("lu_released", 32'(bus.stage_en), 32'(5'b11111));
        tick(1'b1, 1'b0);
        check("lu_valid1", 32'(bus.stage_valid), 32'(5'b10111));
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("lu_valid2", 32'(bus.stage_valid), 32'(5'b01111));
        tick(1'b0, 1'b0);
        check("lu_valid3", 32'(bus.stage_valid), 32'(5'b11111));
        check("lu_stall1", 32'(bus.stall_cnt), 32'd1);
        check_counters("lu");

        // A load to x0 never creates a hazard
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick(1'b1, 1'b0);
        set_dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        check("x0_stage_en", 32'(bus.stage_en), 32'(5'b11111));
        check("x0_bubble", 32'(bus.stage_bubble), 32'(5'b00000));
        tick(1'b1, 1'b0);
        check("x0_valid", 32'(bus.stage_valid), 32'(5'b11111));

        // Load to x9. The add reads it via rs2; rs1 also matches but is marked unused.
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        tick(1'b1, 1'b0);
        set_dec(5'd9, 1'b0, 5'd9, 1'b1, 5'd3, 1'b1, 1'b0);
        #1;
        check("lu2_bubble", 32'(bus.stage_bubble), 32'(5'b00100));
        tick(1'b1, 1'b1);
        check("lu2_valid0", 32'(bus.stage_valid), 32'(5'b11011));
        tick(1'b1, 1'b0);
        set_dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("lu2_valid3", 32'(bus.stage_valid), 32'(5'b11111));
        check_counters("lu2");

        // Fetch stall alone: bubble into slot 1 and no stall count
        bus.iresp_ok = 1'b0;
        #1;
        check("fs_stage_en", 32'(bus.stage_en), 32'(5'b11110));
        check("fs_bubble", 32'(bus.stage_bubble), 32'(5'b00010));
        tick(1'b1, 1'b0);
        check("fs_valid", 32'(bus.stage_valid), 32'(5'b11101));
        bus.iresp_ok = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("fs_refill", 32'(bus.stage_valid), 32'(5'b11111));

        // dmem_busy held for 3 cycles with slot 3 valid
        bus.dmem_busy = 1'b1;
        #1;
        check("mb_stage_en", 32'(bus.stage_en), 32'(5'b10000));
        check("mb_bubble", 32'(bus.stage_bubble), 32'(5'b10000));
        tick(1'b1, 1'b1);
        check("mb_valid0", 32'(bus.stage_valid), 32'(5'b01111));
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("mb_valid2", 32'(bus.stage_valid), 32'(5'b01111));
        bus.dmem_busy = 1'b0;
        tick(1'b0, 1'b0);
        check("mb_valid3", 32'(bus.stage_valid), 32'(5'b11111));
        check("mb_stall", 32'(bus.stall_cnt), 32'd5);
        check_counters("mb");

        // Taken redirect: slots 1..2 are flushed and slots 3..4 retire
        bus.redirect_valid = 1'b1;
        #1;
        check("rd_pc_redirect", 32'(bus.pc_redirect), 32'(1'b1));
        check("rd_pc_en", 32'(bus.pc_en), 32'(1'b1));
        check("rd_bubble", 32'(bus.stage_bubble), 32'(5'b00110));
        tick(1'b1, 1'b0);
        check("rd_valid0", 32'(bus.stage_valid), 32'(5'b11001));
        bus.redirect_valid = 1'b0;
        tick(1'b1, 1'b0);
        check("rd_valid1", 32'(bus.stage_valid), 32'(5'b10011));
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rd_refill", 32'(bus.stage_valid), 32'(5'b11111));

        // A redirect during dmem_busy waits until the busy signal drops
        bus.redirect_valid = 1'b1;
        bus.dmem_busy      = 1'b1;
        #1;
        check("rdb_ignored", 32'(bus.pc_redirect), 32'(1'b0));
        check("rdb_stage_en", 32'(bus.stage_en), 32'(5'b10000));
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        bus.dmem_busy = 1'b0;
        #1;
        check("rdb_taken", 32'(bus.pc_redirect), 32'(1'b1));
        tick(1'b0, 1'b0);
        check("rdb_valid", 32'(bus.stage_valid), 32'(5'b11001));
        bus.redirect_valid = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("rdb_refill", 32'(bus.stage_valid), 32'(5'b11111));

        // A redirect takes priority over a pending fetch
        bus.redirect_valid = 1'b1;
        bus.iresp_ok       = 1'b0;
        #1;
        check("rdf_pc_en", 32'(bus.pc_en), 32'(1'b1));
        check("rdf_stage_en", 32'(bus.stage_en), 32'(5'b11111));
        tick(1'b1, 1'b0);
        check("rdf_valid", 32'(bus.stage_valid), 32'(5'b11001));
        bus.redirect_valid = 1'b0;
        bus.iresp_ok       = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check_counters("rdf");

        // Run instr_cnt up to all-ones, then one more commit wraps it to zero
        guard = 0;
        while (exp_instr != 8'hff && guard < 400) begin
            tick(1'b1, 1'b0);
            guard++;
        end
        check("wrap_at_max", 32'(bus.instr_cnt), 32'hff);
        tick(1'b1, 1'b0);
        check("wrap_to_zero", 32'(bus.instr_cnt), 32'h00);
        check_counters("wrap");

        // Assert reset mid-stall and mid-redirect with every slot valid
        check("prerst_valid", 32'(bus.stage_valid), 32'(5'b11111));
        bus.dmem_busy      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.iresp_ok       = 1'b0;
        reset              = 1'b1;
        #1;
        check("mrst_stage_en", 32'(bus.stage_en), 32'(5'b11111));
        check("mrst_commit", 32'(bus.commit_valid), 32'(1'b0));
        check("mrst_pc_redirect", 32'(bus.pc_redirect), 32'(1'b0));
        @(posedge clk);
        #1;
        exp_cycle = 8'd0;
        exp_instr = 8'd0;
        exp_stall = 8'd0;
        check("mrst_valid", 32'(bus.stage_valid), 32'(5'b00000));
        check_counters("mrst");
        reset              = 1'b0;
        bus.dmem_busy      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.iresp_ok       = 1'b1;
        tick(1'b0, 1'b0);
        check("post_rst_valid", 32'(bus.stage_valid), 32'(5'b00011));
        check_counters("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter NSTAGE, default 5, meaning the number of pipeline slots (legal 3..8); slot 0 is fetch and slot NSTAGE-1 is writeback.
REQ-002 The block SHALL have parameter BR_STAGE, default 2, meaning the slot that raises redirects (legal 2..NSTAGE-2).
REQ-003 The block SHALL have parameter MEM_STAGE, default 3, meaning the slot that raises memory-busy stalls (legal BR_STAGE..NSTAGE-2).
REQ-004 The block SHALL have parameter CNT_W, default 64, meaning the width of the performance counters.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high; ports clk and reset.
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 iresp_ok  in  1  the instruction fetch for slot 0 completes this cycle.
REQ-009 dmem_busy  in  1  the slot MEM_STAGE data access is still outstanding.
REQ-010 redirect_valid  in  1  slot BR_STAGE resolved a taken jump or branch.
REQ-011 dec_rs1, dec_rs2  in  5 each  source registers of the slot 1 instruction.
REQ-012 dec_rs1_used, dec_rs2_used  in  1 each  the source register is actually read.
REQ-013 dec_rd  in  5  destination register of the slot 1 instruction.
REQ-014 dec_regwrite, dec_memread  in  1 each  the slot 1 instruction writes rd / is a load.
REQ-015 stage_en  out  NSTAGE  slot k register loads this cycle.
REQ-016 stage_bubble  out  NSTAGE  slot k loads a bubble instead of slot k-1 contents.
REQ-017 stage_valid  out  NSTAGE  slot k holds a live instruction.
REQ-018 pc_en  out  1  the PC register advances.
REQ-019 pc_redirect  out  1  the PC loads the redirect target instead of pc+4.
REQ-020 commit_valid  out  1  slot NSTAGE-1 retires an instruction this cycle.
REQ-021 cycle_cnt, instr_cnt, stall_cnt  out  CNT_W each  performance counters.

Function
REQ-022 The block SHALL compute per-slot hold requests: hold[0]=!iresp_ok; hold[1]=load_use; hold[MEM_STAGE]=dmem_busy&stage_valid[MEM_STAGE]; all others 0.
REQ-023 freeze[k] SHALL be the OR of hold[j] for all j>=k; stage_en[k]=!freeze[k]; pc_en=!freeze[0].
REQ-024 When freeze[k-1]&!freeze[k], slot k SHALL load a bubble (valid 0) and stage_bubble[k]=1.
REQ-025 load_use SHALL be stage_valid[1]&stage_valid[2]&sb_memread[2]&sb_regwrite[2]&(sb_rd[2]!=0)&((dec_rs1_used&dec_rs1==sb_rd[2])|(dec_rs2_used&dec_rs2==sb_rd[2])); it SHALL insert exactly one bubble per load.
REQ-026 The block SHALL keep a scoreboard of rd, regwrite and memread for slots 2..NSTAGE-1, captured from dec_* when slot 2 loads from slot 1, shifted with stage_en, and cleared by a bubble.
REQ-027 A redirect SHALL be taken iff redirect_valid&stage_valid[BR_STAGE]&!freeze[BR_STAGE]; a redirect that is not taken is ignored, and the source holds it.
REQ-028 A taken redirect SHALL assert pc_redirect and pc_en, and SHALL clear stage_valid of slots 1..BR_STAGE on the next edge.
REQ-029 A taken redirect SHALL take priority over load_use and hold[0].
REQ-030 Slot 1 SHALL become valid only when slot 0 fetch completes (iresp_ok) and no redirect is taken.
REQ-031 commit_valid SHALL equal stage_valid[NSTAGE-1] and is combinational.
REQ-032 cycle_cnt SHALL increment every non-reset cycle.
REQ-033 instr_cnt SHALL increment when commit_valid=1.
REQ-034 stall_cnt SHALL increment when freeze[1]=1.
REQ-035 All counters SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-036 reset SHALL clear stage_valid, all scoreboard entries and all counters to 0 within one edge, including when asserted mid-stall or mid-redirect.
REQ-037 While reset is asserted, stage_en SHALL be all ones, pc_redirect=0 and commit_valid=0.
REQ-038 The first commit SHALL occur no earlier than NSTAGE cycles after reset is released.

Verification
REQ-039 Reset released, iresp_ok=1 steady, no hazards -> commit_valid first high on cycle 5 after reset, then every cycle; instr_cnt=N-4 after N cycles.
REQ-040 Load to x5 followed by add using x5 -> one bubble in slot 2, stall_cnt=1, dependent commits one cycle late; same case with rd=x0 -> no bubble.
REQ-041 dmem_busy for 3 cycles with slot 3 valid -> slots 0..3 hold 3 cycles, slot 4 gets 3 bubbles, stall_cnt+=3.
REQ-042 redirect_valid with slot 2 valid -> pc_redirect=1, slots 1..2 invalid next cycle, no instructions lost from slots 3..4; redirect with simultaneous dmem_busy -> ignored until busy drops.
REQ-043 instr_cnt preset to 2^CNT_W-1 (CNT_W=8 build: 255) plus one commit -> reads 0.
REQ-044 reset asserted mid-stall with all slots valid -> next cycle stage_valid=0 and all counters=0.
